// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between a requesting datapath and the bit-serial adder.
// The master drives the operands and start; the slave returns busy/done and the result.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (output start, a, b, carry_in, input busy, done, sum, carry);
  modport slave  (input start, a, b, carry_in, output busy, done, sum, carry);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full_adder cell adds two WIDTH-bit operands LSB first,
// one bit per clock, and returns {carry,sum} with a one-cycle done pulse.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a    (sha[0]),
    .b    (shb[0]),
    .cin  (c),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // New sum bit enters at the MSB so the first (LSB) bit ends up at bit 0 after WIDTH shifts.
  assign acc_next = {fa_sum, {(WIDTH-1){1'b0}}} | (acc >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sha       <= '0;
      shb       <= '0;
      acc       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.sum   <= '0;
      bus.carry <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            sha      <= bus.a;
            shb      <= bus.b;
            c        <= bus.carry_in;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sha <= sha >> 1;
          shb <= shb >> 1;
          acc <= acc_next;
          c   <= fa_carry;
          cnt <= cnt + 1'b1;
          // Result registers are only touched here, so they never expose a partial sum.
          if (cnt == LAST) begin
            bus.sum   <= acc_next;
            bus.carry <= fa_carry;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder_ctrl;
  logic       clk;
  logic       rst_n;
  int         vec_count;
  int         miss_count;
  logic [8:0] last_exp;

  serial_adder_ctrl_if #(.WIDTH(8)) s8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) s4 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(s8.slave));
  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(s4.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after an edge with the 8-bit unit idle; leaves it idle again.
  task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [7:0] bv,
                               input logic cin, input logic [8:0] expv);
    int n;
    bit held;
    s8.start = 1'b1;
    s8.a = av;
    s8.b = bv;
    s8.carry_in = cin;
    step();
    s8.start = 1'b0;
    s8.a = ~av;
    s8.b = ~bv;
    s8.carry_in = ~cin;
    n = 0;
    held = 1'b1;
    while (s8.busy && n < 20) begin
      if ({s8.carry, s8.sum} !== last_exp) held = 1'b0;
      n++;
      step();
    end
    checkOutput({tag, " busy cycles"}, n, 8);
    checkOutput({tag, " result hold"}, held, 1);
    checkOutput({tag, " done"}, s8.done, 1);
    checkOutput({tag, " result"}, {s8.carry, s8.sum}, expv);
    last_exp = expv;
    step();
    checkOutput({tag, " done width"}, s8.done, 0);
  endtask

  initial begin
    int n;
    bit held;
    vec_count = 0;
    miss_count = 0;
    last_exp = '0;
    rst_n = 1'b0;
    s8.start = 1'b0; s8.a = '0; s8.b = '0; s8.carry_in = 1'b0;
    s4.start = 1'b0; s4.a = '0; s4.b = '0; s4.carry_in = 1'b0;
    #3;
    checkOutput("reset busy", s8.busy, 0);
    checkOutput("reset done", s8.done, 0);
    checkOutput("reset result", {s8.carry, s8.sum}, 0);
    checkOutput("reset w4 result", {s4.busy, s4.done, s4.carry, s4.sum}, 0);
    #9 rst_n = 1'b1;
    step();

    applyStimulus("zero", 8'h00, 8'h00, 1'b0, 9'h000);
    applyStimulus("ripple", 8'hff, 8'h01, 1'b0, 9'h100);
    applyStimulus("max", 8'hff, 8'hff, 1'b1, 9'h1ff);

    // Held start: ignored while busy, accepted again in DONE with new operands.
    s8.start = 1'b1; s8.a = 8'h5a; s8.b = 8'ha5; s8.carry_in = 1'b0;
    step();
    n = 0;
    while (s8.busy && n < 20) begin
      n++;
      step();
    end
    checkOutput("held busy cycles", n, 8);
    checkOutput("held done", s8.done, 1);
    checkOutput("held result", {s8.carry, s8.sum}, 9'h0ff);
    last_exp = 9'h0ff;
    s8.a = 8'h10; s8.b = 8'h20; s8.carry_in = 1'b1;
    step();
    s8.start = 1'b0;
    checkOutput("b2b busy", s8.busy, 1);
    checkOutput("b2b done low", s8.done, 0);
    n = 0;
    held = 1'b1;
    while (s8.busy && n < 20) begin
      if ({s8.carry, s8.sum} !== last_exp) held = 1'b0;
      n++;
      step();
    end
    checkOutput("b2b busy cycles", n, 8);
    checkOutput("b2b result hold", held, 1);
    checkOutput("b2b done", s8.done, 1);
    checkOutput("b2b result", {s8.carry, s8.sum}, 9'h031);
    last_exp = 9'h031;
    step();
    checkOutput("b2b done width", s8.done, 0);

    // Reset in the middle of RUN clears outputs without a clock edge.
    s8.start = 1'b1; s8.a = 8'h33; s8.b = 8'h44; s8.carry_in = 1'b0;
    step();
    s8.start = 1'b0;
    step();
    step();
    step();
    checkOutput("pre-abort busy", s8.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", s8.busy, 0);
    checkOutput("abort done", s8.done, 0);
    checkOutput("abort result", {s8.carry, s8.sum}, 0);
    #2 rst_n = 1'b1;
    last_exp = '0;
    step();
    applyStimulus("post-reset", 8'hc3, 8'h3c, 1'b1, 9'h100);

    // Exhaustive 4-bit sweep against the arithmetic definition.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int ci = 0; ci < 2; ci++) begin
          s4.start = 1'b1;
          s4.a = av[3:0];
          s4.b = bv[3:0];
          s4.carry_in = ci[0];
          step();
          s4.start = 1'b0;
          n = 0;
          while (!s4.done && n < 10) begin
            n++;
            step();
          end
          checkOutput($sformatf("w4 latency %0h+%0h+%0d", av, bv, ci), n, 4);
          checkOutput($sformatf("w4 sum %0h+%0h+%0d", av, bv, ci), {s4.carry, s4.sum}, av + bv + ci);
          step();
          checkOutput($sformatf("w4 done width %0h+%0h+%0d", av, bv, ci), s4.done, 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule
